rect_run_packer: RTL

//  Packs the rectifier's per-pixel output stream (one byte per accepted cycle, arbitrary lr/ydst/xdst)

---
 rtl/rect_run_packer_pkg.sv | 17 +
 rtl/rect_pack_ram.sv | 23 ++
 rtl/rect_run_packer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/rect_run_packer_pkg.sv
// Shared constants and run-metadata type for the rectifier run packer.
package rect_run_packer_pkg;
  localparam int MAX_LEN = 127;
  localparam int AW      = 7;
  localparam int YDST_W  = 9;
  localparam int XDST_W  = 10;
  localparam int PIX_W   = 8;
  localparam int LEN_W   = 7;

  typedef struct packed {
    logic              last;
    logic              lr;
    logic [YDST_W-1:0] ydst;
    logic [XDST_W-1:0] xdst;
    logic [LEN_W-1:0]  len;
  } run_meta_t;
endpackage

// File: rtl/rect_pack_ram.sv
// Two-bank simple dual-port byte RAM; bank select on both ports, 1-cycle sync read.
module rect_pack_ram
  import rect_run_packer_pkg::*;
#(
  parameter int AW = 7
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic             i_wbank,
  input  logic [AW-1:0]    i_waddr,
  input  logic [PIX_W-1:0] i_wdata,
  input  logic             i_re,
  input  logic             i_rbank,
  input  logic [AW-1:0]    i_raddr,
  output logic [PIX_W-1:0] o_rdata
);
  logic [PIX_W-1:0] r_mem [2**(AW+1)];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[{i_wbank, i_waddr}] <= i_wdata;
    if (i_re) o_rdata <= r_mem[{i_rbank, i_raddr}];
  end
endmodule

// File: rtl/rect_run_packer.sv
// Packs the rectified pixel stream into contiguous column runs and replays each
// run as a burst with constant metadata; one bank fills while the other replays.
module rect_run_packer #(
  parameter int MAX_LEN = rect_run_packer_pkg::MAX_LEN,
  parameter int AW      = rect_run_packer_pkg::AW
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   enb,
  input  logic                                   in_vld,
  output logic                                   in_rdy,
  input  logic                                   in_eof,
  input  logic                                   in_lr,
  input  logic [rect_run_packer_pkg::YDST_W-1:0] in_ydst,
  input  logic [rect_run_packer_pkg::XDST_W-1:0] in_xdst,
  input  logic [rect_run_packer_pkg::PIX_W-1:0]  in_pix,
  output logic                                   vin,
  output logic                                   last,
  output logic                                   lr,
  output logic [rect_run_packer_pkg::YDST_W-1:0] ydst,
  output logic [rect_run_packer_pkg::XDST_W-1:0] xdst,
  output logic [rect_run_packer_pkg::LEN_W-1:0]  len,
  output logic [rect_run_packer_pkg::PIX_W-1:0]  intp,
  output logic                                   busy
);
  import rect_run_packer_pkg::*;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // fill side
  logic [1:0]            r_full;
  logic                  r_wsel;
  logic                  r_open;
  logic                  r_lr;
  logic [YDST_W-1:0]     r_y;
  logic [XDST_W-1:0]     r_x0;
  logic [LEN_W-1:0]      r_n;
  run_meta_t [1:0]       r_meta;

  // replay side
  logic [1:0]            r_st;
  logic                  r_rsel;
  logic [LEN_W-1:0]      r_k;
  run_meta_t             r_out;

  logic                  w_acc, w_cont, w_brk, w_new, w_cls, w_wbank, w_run_lr, w_re;
  logic [XDST_W:0]       w_xnext;
  logic [LEN_W-1:0]      w_wn, w_n_after;
  logic [YDST_W-1:0]     w_run_y;
  logic [XDST_W-1:0]     w_run_x0;
  logic [PIX_W-1:0]      w_rdata;

  // Ready looks only at the spare bank so a break-before always has somewhere to go.
  assign in_rdy    = enb & ~r_full[~r_wsel];
  assign w_acc     = in_vld & in_rdy;

  // 11-bit compare: column 1023 followed by 0 is a break, not a wrap.
  assign w_xnext   = {1'b0, r_x0} + (XDST_W+1)'(r_n);
  assign w_cont    = ({1'b0, in_xdst} == w_xnext);
  assign w_brk     = r_open & ((in_lr != r_lr) | (in_ydst != r_y) | ~w_cont |
                               (r_n == LEN_W'(MAX_LEN)));
  assign w_new     = w_brk | ~r_open;
  assign w_wbank   = r_wsel ^ w_brk;
  assign w_wn      = w_new ? '0 : r_n;
  assign w_n_after = w_wn + LEN_W'(1);
  assign w_cls     = in_eof | (w_n_after == LEN_W'(MAX_LEN));
  assign w_run_lr  = w_new ? in_lr   : r_lr;
  assign w_run_y   = w_new ? in_ydst : r_y;
  assign w_run_x0  = w_new ? in_xdst : r_x0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= '0;
      r_wsel <= 1'b0;
      r_open <= 1'b0;
      r_lr   <= 1'b0;
      r_y    <= '0;
      r_x0   <= '0;
      r_n    <= '0;
      r_meta <= '0;
    end else if (!enb) begin
      r_full <= '0;
      r_wsel <= 1'b0;
      r_open <= 1'b0;
      r_lr   <= 1'b0;
      r_y    <= '0;
      r_x0   <= '0;
      r_n    <= '0;
      r_meta <= '0;
    end else begin
      if (r_st == S_DONE) r_full[r_rsel] <= 1'b0;
      if (w_acc) begin
        if (w_brk) begin
          r_full[r_wsel] <= 1'b1;
          r_meta[r_wsel] <= '{last: 1'b0, lr: r_lr, ydst: r_y, xdst: r_x0, len: r_n};
        end
        if (w_cls) begin
          r_full[w_wbank] <= 1'b1;
          r_meta[w_wbank] <= '{last: in_eof, lr: w_run_lr, ydst: w_run_y,
                               xdst: w_run_x0, len: w_n_after};
          r_open <= 1'b0;
        end else begin
          r_open <= 1'b1;
          r_n    <= w_n_after;
        end
        r_lr   <= w_run_lr;
        r_y    <= w_run_y;
        r_x0   <= w_run_x0;
        // break-before and close-after each hand the write side to the other bank
        r_wsel <= w_wbank ^ w_cls;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st   <= S_IDLE;
      r_rsel <= 1'b0;
      r_k    <= '0;
      r_out  <= '0;
    end else if (!enb) begin
      r_st   <= S_IDLE;
      r_rsel <= 1'b0;
      r_k    <= '0;
      r_out  <= '0;
    end else begin
      case (r_st)
        S_IDLE: if (r_full[r_rsel]) begin
          r_st  <= S_RD;
          r_out <= r_meta[r_rsel];
          r_k   <= '0;
        end
        S_RD: begin
          r_st <= S_PLAY;
          r_k  <= LEN_W'(1);
        end
        // r_k is one ahead of the byte on intp: it is the next read address
        S_PLAY: begin
          if (r_k == r_out.len) r_st <= S_DONE;
          else                  r_k  <= r_k + LEN_W'(1);
        end
        S_DONE: begin
          r_st   <= S_IDLE;
          r_rsel <= ~r_rsel;
        end
        default: r_st <= S_IDLE;
      endcase
    end
  end

  assign w_re = (r_st == S_RD) | (r_st == S_PLAY);

  rect_pack_ram #(.AW(AW)) u_ram (
    .clk     (clk),
    .i_we    (w_acc),
    .i_wbank (w_wbank),
    .i_waddr (AW'(w_wn)),
    .i_wdata (in_pix),
    .i_re    (w_re),
    .i_rbank (r_rsel),
    .i_raddr (AW'(r_k)),
    .o_rdata (w_rdata)
  );

  assign vin  = (r_st == S_PLAY);
  assign intp = vin ? w_rdata : '0;
  assign last = r_out.last;
  assign lr   = r_out.lr;
  assign ydst = r_out.ydst;
  assign xdst = r_out.xdst;
  assign len  = r_out.len;
  assign busy = r_open | (|r_full);
endmodule
